// File: rtl/state_dump_reader_pkg.sv
// state_dump_reader shared definitions
// scan states, beat kinds, default sizes
package state_dump_reader_pkg;

  localparam int REG_COUNT_DEF = 32;
  localparam int MEM_WORDS_DEF = 64;
  localparam int IDX_W_DEF     = 7;

  localparam logic KIND_REG = 1'b0;
  localparam logic KIND_MEM = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN_REG,
    ST_SCAN_MEM,
    ST_HOLD,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic        kind;
    logic [31:0] index;
    logic [31:0] value;
  } beat_t;

endpackage

// File: rtl/state_dump_reader_if.sv
// state_dump_reader output beat stream
// valid/ready handshake carrying (kind, index, value)
interface state_dump_reader_if;
  logic        out_valid;
  logic        out_ready;
  logic        out_kind;
  logic [31:0] out_index;
  logic [31:0] out_value;

  modport master (
    output out_valid, out_kind, out_index, out_value,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_kind, out_index, out_value,
    output out_ready
  );
endinterface

// File: rtl/state_dump_reader_scan_counter.sv
// state_dump_reader scan counter
// walks registers (phase 0) then memory words (phase 1)
module state_dump_reader_scan_counter #(
  parameter int REG_COUNT = 32,
  parameter int MEM_WORDS = 64,
  parameter int IDX_W     = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             advance_i,
  output logic [IDX_W-1:0] cnt_o,
  output logic             phase_o,
  output logic             phase_last_o,
  output logic             scan_last_o
);

  localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(REG_COUNT - 1);
  localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_WORDS - 1);

  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  assign scan_last_o  = phase_q ? (cnt_q == MEM_LAST)
                                : (cnt_q == REG_LAST);
  assign phase_last_o = phase_q;
  assign cnt_o        = cnt_q;
  assign phase_o      = phase_q;

  // next count: wrap to 0 and flip phase at the end of a phase
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clear_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (advance_i) begin
      if (scan_last_o) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // counter and phase registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/state_dump_reader.sv
// state_dump_reader: dumps nonzero register and
// memory entries as a valid/ready beat stream
module state_dump_reader
  import state_dump_reader_pkg::*;
#(
  parameter int REG_COUNT = REG_COUNT_DEF,
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int IDX_W     = IDX_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  reg_a,
  input  logic [31:0] reg_rd,
  output logic [31:0] mem_a,
  input  logic [31:0] mem_rd,
  state_dump_reader_if.master stream
);

  state_e           state_q, state_d;
  beat_t            beat_q, beat_d;
  logic             valid_q, valid_d;
  logic             clear, advance;
  logic [IDX_W-1:0] cnt;
  logic             phase, phase_last, scan_last;
  logic [31:0]      rd;
  logic [31:0]      idx;
  state_e           after_adv;

  state_dump_reader_scan_counter #(
    .REG_COUNT (REG_COUNT),
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (IDX_W)
  ) u_cnt (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (clear),
    .advance_i    (advance),
    .cnt_o        (cnt),
    .phase_o      (phase),
    .phase_last_o (phase_last),
    .scan_last_o  (scan_last)
  );

  assign reg_a = cnt[4:0];
  assign mem_a = 32'({cnt, 2'b00});
  assign rd    = phase ? mem_rd : reg_rd;
  assign idx   = phase ? mem_a : 32'(cnt);
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);

  assign stream.out_valid = valid_q;
  assign stream.out_kind  = beat_q.kind;
  assign stream.out_index = beat_q.index;
  assign stream.out_value = beat_q.value;

  // where the scan goes once the counter advances
  always_comb begin
    after_adv = phase ? ST_SCAN_MEM : ST_SCAN_REG;
    if (scan_last)
      after_adv = phase_last ? ST_DONE : ST_SCAN_MEM;
  end

  // scan FSM: next state, counter control, beat latch
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    clear   = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = ST_SCAN_REG;
        end
      end
      ST_SCAN_REG, ST_SCAN_MEM: begin
        if (rd != '0) begin
          beat_d  = '{kind: phase ? KIND_MEM : KIND_REG,
                      index: idx, value: rd};
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else begin
          advance = 1'b1;
          state_d = after_adv;
        end
      end
      ST_HOLD: begin
        if (stream.out_ready) begin
          valid_d = 1'b0;
          advance = 1'b1;
          state_d = after_adv;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // state and output beat registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_state_dump_reader.sv
// state_dump_reader directed testbench
module tb_state_dump_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done;
  logic [4:0]  reg_a;
  logic [31:0] reg_rd, mem_a, mem_rd;

  logic [31:0] regs [32];
  logic [31:0] memw [64];

  int n_chk = 0;
  int n_err = 0;

  logic        bk [$];
  logic [31:0] bi [$];
  logic [31:0] bv [$];
  int          bat [$];
  int          done_at, done_cnt, idle_at;

  state_dump_reader_if sif ();

  state_dump_reader dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .reg_a  (reg_a),
    .reg_rd (reg_rd),
    .mem_a  (mem_a),
    .mem_rd (mem_rd),
    .stream (sif)
  );

  assign reg_rd = regs[reg_a];
  assign mem_rd = memw[mem_a[7:2]];

  always #5 clk = ~clk;

  task automatic clr_store();
    for (int i = 0; i < 32; i++) regs[i] = '0;
    for (int i = 0; i < 64; i++) memw[i] = '0;
  endtask

  // pulses start, then records beats/done per negedge k
  // (negedge k lies between start edge + k-1 and + k)
  task automatic collect(input int maxc, input int ra,
                         input int rb, input bit stop_idle);
    bk.delete(); bi.delete(); bv.delete(); bat.delete();
    done_at = -1; done_cnt = 0; idle_at = -1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      start = (k == ra) || (k == rb);
      if (sif.out_valid && sif.out_ready) begin
        bk.push_back(sif.out_kind);
        bi.push_back(sif.out_index);
        bv.push_back(sif.out_value);
        bat.push_back(k);
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (done_cnt > 0 && !busy && idle_at < 0) begin
        idle_at = k;
        if (stop_idle) break;
      end
    end
    start = 1'b0;
    if (stop_idle) begin
      n_chk++;
      if (idle_at < 0) begin
        n_err++;
        $display("FAIL timeout: no done/idle within %0d", maxc);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_chk++;
    if ({busy, done, sif.out_valid, sif.out_kind} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_ctl: got %b exp 0000",
               {busy, done, sif.out_valid, sif.out_kind});
    end
    n_chk++;
    if ({sif.out_index, sif.out_value, mem_a} !== 96'b0
        || reg_a !== 5'd0) begin
      n_err++;
      $display("FAIL reset_data: idx %0h val %0h mem_a %0h reg_a %0d",
               sif.out_index, sif.out_value, mem_a, reg_a);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_two_beats(input string nm);
    n_chk++;
    if (bk.size() !== 2) begin
      n_err++;
      $display("FAIL %s_count: got %0d exp 2", nm, bk.size());
    end else begin
      n_chk++;
      if ({bk[0], bi[0], bv[0]} !== {1'b0, 32'd8, 32'd5}) begin
        n_err++;
        $display("FAIL %s_beat0: got %0d,%0d,%0d exp 0,8,5",
                 nm, bk[0], bi[0], bv[0]);
      end
      n_chk++;
      if ({bk[1], bi[1], bv[1]} !== {1'b0, 32'd9, 32'd7}) begin
        n_err++;
        $display("FAIL %s_beat1: got %0d,%0d,%0d exp 0,9,7",
                 nm, bk[1], bi[1], bv[1]);
      end
    end
    n_chk++;
    if (done_at !== 99) begin
      n_err++;
      $display("FAIL %s_done_at: got %0d exp 99", nm, done_at);
    end
    n_chk++;
    if (idle_at !== 100) begin
      n_err++;
      $display("FAIL %s_idle_at: got %0d exp 100", nm, idle_at);
    end
  endtask

  task automatic test_two_regs();
    clr_store();
    regs[8] = 32'd5;
    regs[9] = 32'd7;
    sif.out_ready = 1'b1;
    collect(300, 0, 0, 1'b1);
    chk_two_beats("two_regs");
  endtask

  task automatic test_last_mem();
    clr_store();
    memw[63] = 32'hDEADBEEF;
    sif.out_ready = 1'b1;
    collect(300, 0, 0, 1'b1);
    n_chk++;
    if (bk.size() !== 1) begin
      n_err++;
      $display("FAIL last_mem_count: got %0d exp 1", bk.size());
    end else begin
      n_chk++;
      if ({bk[0], bi[0], bv[0]} !== {1'b1, 32'd252, 32'hDEADBEEF}) begin
        n_err++;
        $display("FAIL last_mem_beat: got %0d,%0d,%0h exp 1,252,deadbeef",
                 bk[0], bi[0], bv[0]);
      end
      n_chk++;
      if (bat[0] !== 97 || done_at !== 98) begin
        n_err++;
        $display("FAIL last_mem_timing: beat %0d done %0d exp 97 98",
                 bat[0], done_at);
      end
    end
  endtask

  task automatic test_backpressure();
    int k;
    bit seen;
    clr_store();
    regs[1] = 32'd3;
    sif.out_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_chk++;
      if ({sif.out_valid, sif.out_kind, sif.out_index, sif.out_value}
          !== {1'b1, 1'b0, 32'd1, 32'd3} || reg_a !== 5'd1) begin
        n_err++;
        $display("FAIL hold_%0d: v %0d beat %0d,%0d,%0d reg_a %0d exp 1 0,1,3 1",
                 i, sif.out_valid, sif.out_kind, sif.out_index,
                 sif.out_value, reg_a);
      end
    end
    sif.out_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (sif.out_valid !== 1'b0 || reg_a !== 5'd2) begin
      n_err++;
      $display("FAIL hold_accept: v %0d reg_a %0d exp 0 2",
               sif.out_valid, reg_a);
    end
    seen = 1'b0;
    k = 13;
    while (!seen && k < 300) begin
      @(negedge clk);
      k++;
      if (done) seen = 1'b1;
    end
    n_chk++;
    if (k !== 107) begin
      n_err++;
      $display("FAIL hold_done_at: got %0d exp 107", k);
    end
  endtask

  task automatic test_all_zero();
    clr_store();
    sif.out_ready = 1'b1;
    collect(300, 0, 0, 1'b1);
    n_chk++;
    if (bk.size() !== 0) begin
      n_err++;
      $display("FAIL zero_count: got %0d exp 0", bk.size());
    end
    n_chk++;
    if (done_at !== 97) begin
      n_err++;
      $display("FAIL zero_done_at: got %0d exp 97", done_at);
    end
  endtask

  task automatic test_async_reset();
    clr_store();
    regs[8] = 32'd5;
    regs[9] = 32'd7;
    sif.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 2; k <= 55; k++) @(negedge clk);
    n_chk++;
    if (busy !== 1'b1 || mem_a !== 32'd80) begin
      n_err++;
      $display("FAIL mid_scan: busy %0d mem_a %0d exp 1 80", busy, mem_a);
    end
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if ({busy, done, sif.out_valid} !== 3'b0
        || mem_a !== 32'd0 || reg_a !== 5'd0) begin
      n_err++;
      $display("FAIL async_reset: b/d/v %b mem_a %0d reg_a %0d exp 000 0 0",
               {busy, done, sif.out_valid}, mem_a, reg_a);
    end
    @(negedge clk);
    reset = 1'b0;
    collect(300, 0, 0, 1'b1);
    chk_two_beats("rescan");
  endtask

  task automatic test_back_to_back();
    clr_store();
    regs[8] = 32'd5;
    regs[9] = 32'd7;
    sif.out_ready = 1'b1;
    collect(200, 50, 99, 1'b0);
    chk_two_beats("restart");
    n_chk++;
    if (done_cnt !== 1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL restart_once: dones %0d busy %0d exp 1 0",
               done_cnt, busy);
    end
  endtask

  initial begin
    sif.out_ready = 1'b1;
    clr_store();
    test_reset();
    test_two_regs();
    test_last_mem();
    test_backpressure();
    test_all_zero();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
